// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared settings for the FIFO family.
// Holds the read-mode enum and the threshold comparison used for the
// almost-full / almost-empty flags.
package rtl_settings_pkg;

  // Read-port behaviour of fifo_ext.
  typedef enum logic {
    FIFO_NORMAL    = 1'b0,  // q_o registered, one cycle after an accepted read
    FIFO_SHOWAHEAD = 1'b1   // q_o shows the head word combinationally
  } fifo_mode_t;

  // Threshold test: at_or_above=1 -> level >= thresh, else level <= thresh.
  function automatic logic thresh_met(input int unsigned level,
                                      input int unsigned thresh,
                                      input logic        at_or_above);
    return at_or_above ? (level >= thresh) : (level <= thresh);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port storage array for fifo_ext.
// One synchronous write port; the read port is either registered (REG_OUT=1,
// updates only when re_i is high, holds otherwise) or purely combinational.
module fifo_mem #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word on an accepted write.
  // NOTE: the array has no reset; clearing it would forbid RAM inference and
  // the control logic never exposes a word that was not written first.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [DWIDTH-1:0] rdata_q;

      // Capture the addressed word on a read; hold it between reads.
      always_ff @(posedge clk_i) begin
        if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end

      assign rdata_o = rdata_q;
    end else begin : g_comb_out
      logic unused_re;

      assign unused_re = re_i;
      assign rdata_o   = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/fifo_ext.sv
// fifo_ext: parametrised single-clock FIFO with normal or show-ahead read,
// full-depth occupancy count, almost-full/almost-empty thresholds and
// protection against overflow and underflow (dropped requests change nothing).
// Build option: define FIFO_ERR_FLAGS_EN to add err_clr_i and the sticky
// ovf_o / udf_o drop indicators.
module fifo_ext
  import rtl_settings_pkg::*;
#(
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned DWIDTH    = 8,
  parameter fifo_mode_t  SHOWAHEAD = FIFO_NORMAL,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic              err_clr_i,
  output logic              ovf_o,
  output logic              udf_o
`endif
);

  localparam int unsigned     DEPTH     = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = DEPTH[AWIDTH:0];

  logic              rd_acc;
  logic              wr_acc;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              empty_q, full_q, ae_q, af_q;
  logic [DWIDTH-1:0] mem_rdata;

  // A read needs data; a write needs room, or a read in the same cycle freeing a slot.
  assign rd_acc = rdreq_i & ~empty_q;
  assign wr_acc = wrreq_i & (~full_q | rd_acc);

  // Next-state pointers and occupancy from the accepted requests only.
  always_comb begin
    // NOTE: every signal of this block is defaulted first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    end
    cnt_d = cnt_q + (AWIDTH + 1)'(wr_acc) - (AWIDTH + 1)'(rd_acc);
  end

  // Pointers, count and every status flag update together from the next count.
  // NOTE: state registers use non-blocking assignments so all of them sample
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == DEPTH_CNT);
      ae_q     <= thresh_met(32'(cnt_d), AE_THRESH, 1'b0);
      af_q     <= thresh_met(32'(cnt_d), AF_THRESH, 1'b1);
    end
  end

  fifo_mem #(
    .AWIDTH  (AWIDTH),
    .DWIDTH  (DWIDTH),
    .REG_OUT (SHOWAHEAD == FIFO_NORMAL)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (SHOWAHEAD == FIFO_NORMAL) begin : g_normal
      logic q_vld_q;

      // Masks the unreset read register to zero until the first read after reset.
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          q_vld_q <= 1'b0;
        end else if (rd_acc) begin
          q_vld_q <= 1'b1;
        end
      end

      assign q_o = q_vld_q ? mem_rdata : '0;
    end else begin : g_showahead
      assign q_o = mem_rdata;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky drop indicators; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (wrreq_i & ~wr_acc) | (ovf_q & ~err_clr_i);
      udf_q <= (rdreq_i & ~rd_acc) | (udf_q & ~err_clr_i);
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;
  assign usedw_o        = cnt_q;

endmodule

// File: tb/tb_fifo_ext.sv
// tb_fifo_ext: drives a normal-read and a show-ahead instance with identical
// stimulus and compares both against a queue-based FIFO model.
module tb_fifo_ext;
  import rtl_settings_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       wrreq_i;
  logic       rdreq_i;
  logic [7:0] data_i;

  logic [7:0] q_n, q_s;
  logic       empty_n, empty_s, full_n, full_s;
  logic       ae_n, ae_s, af_n, af_s;
  logic [4:0] usedw_n, usedw_s;

`ifdef FIFO_ERR_FLAGS_EN
  logic err_clr_i;
  logic ovf_n, ovf_s, udf_n, udf_s;
  logic m_ovf, m_udf;
`endif

  // Reference model: contents in order, plus the last word popped.
  logic [7:0] mdl[$];
  logic [7:0] exp_qn;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fifo_ext #(.SHOWAHEAD(FIFO_NORMAL)) dut_n (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .wrreq_i        (wrreq_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .q_o            (q_n),
    .empty_o        (empty_n),
    .full_o         (full_n),
    .almost_empty_o (ae_n),
    .almost_full_o  (af_n),
    .usedw_o        (usedw_n)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .err_clr_i      (err_clr_i),
    .ovf_o          (ovf_n),
    .udf_o          (udf_n)
`endif
  );

  fifo_ext #(.SHOWAHEAD(FIFO_SHOWAHEAD)) dut_s (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .wrreq_i        (wrreq_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .q_o            (q_s),
    .empty_o        (empty_s),
    .full_o         (full_s),
    .almost_empty_o (ae_s),
    .almost_full_o  (af_s),
    .usedw_o        (usedw_s)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .err_clr_i      (err_clr_i),
    .ovf_o          (ovf_s),
    .udf_o          (udf_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mdl.size();
    check("usedw_n", 32'(usedw_n), 32'(n));
    check("usedw_s", 32'(usedw_s), 32'(n));
    check("empty_n", 32'(empty_n), 32'(n == 0));
    check("empty_s", 32'(empty_s), 32'(n == 0));
    check("full_n",  32'(full_n),  32'(n == DEPTH));
    check("full_s",  32'(full_s),  32'(n == DEPTH));
    check("aempty_n", 32'(ae_n), 32'(n <= AE));
    check("aempty_s", 32'(ae_s), 32'(n <= AE));
    check("afull_n",  32'(af_n), 32'(n >= AF));
    check("afull_s",  32'(af_s), 32'(n >= AF));
    check("q_normal", 32'(q_n), 32'(exp_qn));
    if (n != 0) begin
      check("q_showahead", 32'(q_s), 32'(mdl[0]));
    end
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_n", 32'(ovf_n), 32'(m_ovf));
    check("ovf_s", 32'(ovf_s), 32'(m_ovf));
    check("udf_n", 32'(udf_n), 32'(m_udf));
    check("udf_s", 32'(udf_s), 32'(m_udf));
`endif
  endtask

  // One clock of traffic; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    bit rd_ok, wr_ok;
    wrreq_i = wr;
    data_i  = d;
    rdreq_i = rd;
    rd_ok = rd && (mdl.size() != 0);
    wr_ok = wr && ((mdl.size() < DEPTH) || rd_ok);
    @(posedge clk_i);
    #1;
    if (rd_ok) exp_qn = mdl.pop_front();
    if (wr_ok) mdl.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = (wr && !wr_ok) || (m_ovf && !err_clr_i);
    m_udf = (rd && !rd_ok) || (m_udf && !err_clr_i);
    err_clr_i = 1'b0;
`endif
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    mdl.delete();
    exp_qn = 8'h00;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
  endtask

  initial begin
    arst_i  = 1'b1;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
    data_i  = 8'h00;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr_i = 1'b0;
`endif
    model_reset();
    #2;
    check_all();
    #10;
    arst_i = 1'b0;

    // Fill to full, then one dropped write.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);

    // Drain in order, then one dropped read (normal q_o holds the last word).
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1);

    // Single word visible on the show-ahead port without a read, then popped.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);

`ifdef FIFO_ERR_FLAGS_EN
    // Clear both sticky flags, then a clear racing a new underflow keeps udf set.
    err_clr_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    err_clr_i = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    err_clr_i = 1'b1;
    step(1'b0, 8'h00, 1'b0);
`endif

    // Full with simultaneous write and read across pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++)    step(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

    // Empty with simultaneous write and read: write only.
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic, write-biased then read-biased.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 99) < 70), 8'($urandom), 1'($urandom_range(0, 99) < 40));
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 99) < 35), 8'($urandom), 1'($urandom_range(0, 99) < 65));

    // Asynchronous reset between edges with seven words stored.
    while (mdl.size() != 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    #3;
    arst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    arst_i = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
